// File: rtl/led_ctrl_pkg.sv
// Opcodes, FSM encoding and status-byte layout
// shared by the SPI command parser and its bench.
package led_ctrl_pkg;

  localparam logic [7:0] OP_PIXEL  = 8'h01;
  localparam logic [7:0] OP_BRIGHT = 8'h02;
  localparam logic [7:0] OP_SWAP   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h04;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_PIX_R,
    ST_PIX_G,
    ST_PIX_B,
    ST_BRIGHT,
    ST_DISCARD
  } state_t;

  localparam int STAT_ABORT = 0;
  localparam int STAT_CMD   = 1;
  localparam int STAT_SWAP  = 2;

  // States in which losing chip select leaves a half-built item behind
  function automatic logic aborts_in(state_t s);
    return (s == ST_ADDR_H) || (s == ST_ADDR_L) ||
           (s == ST_PIX_G)  || (s == ST_PIX_B);
  endfunction

endpackage

// File: rtl/spi_cmd_parser_if.sv
// Bundle of the parser's SPI-byte, frame-buffer
// and swap signals for the host side and the parser side.
interface spi_cmd_parser_if #(
  parameter int PIX_ADDR_W = 11
);
  logic                  cs_n;
  logic                  mosi_rx;
  logic [7:0]            mosi_data_out;
  logic                  miso_tx;
  logic [7:0]            miso_data_in;
  logic                  fb_we;
  logic [PIX_ADDR_W-1:0] fb_addr;
  logic [23:0]           fb_data;
  logic [7:0]            brightness;
  logic                  swap_req;
  logic                  swap_ack;

  modport master (
    output cs_n, mosi_rx, mosi_data_out, swap_ack,
    input  miso_tx, miso_data_in, fb_we, fb_addr,
    input  fb_data, brightness, swap_req
  );

  modport slave (
    input  cs_n, mosi_rx, mosi_data_out, swap_ack,
    output miso_tx, miso_data_in, fb_we, fb_addr,
    output fb_data, brightness, swap_req
  );
endinterface

// File: rtl/spi_cmd_parser.sv
// Decodes SPI command bytes into frame-buffer writes,
// brightness, buffer-swap requests and a status read-back.
module spi_cmd_parser
  import led_ctrl_pkg::*;
#(
  parameter int PIX_ADDR_W = 11,
  parameter int NUM_PIXELS = 2048
) (
  input  logic                  clk_sb,
  input  logic                  reset_n,
  input  logic                  cs_n,
  input  logic                  mosi_rx,
  input  logic [7:0]            mosi_data_out,
  output logic                  miso_tx,
  output logic [7:0]            miso_data_in,
  output logic                  fb_we,
  output logic [PIX_ADDR_W-1:0] fb_addr,
  output logic [23:0]           fb_data,
  output logic [7:0]            brightness,
  output logic                  swap_req,
  input  logic                  swap_ack
);

  localparam logic [PIX_ADDR_W-1:0] ADDR_LAST =
    PIX_ADDR_W'(NUM_PIXELS - 1);

  logic cs_s1_q, cs_s2_q, cs_s3_q;
  logic active, cs_end, byte_v;

  state_t                state_q, state_d;
  logic [7:0]            addr_hi_q, addr_hi_d;
  logic [PIX_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            r_q, r_d;
  logic [7:0]            g_q, g_d;
  logic                  fb_we_q, fb_we_d;
  logic [PIX_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [23:0]           fb_data_q, fb_data_d;
  logic [7:0]            bright_q, bright_d;
  logic                  swap_q, swap_d;
  logic                  err_cmd_q, err_cmd_d;
  logic                  err_abort_q, err_abort_d;
  logic                  arm_q, arm_d;
  logic                  stat_pend_q, stat_pend_d;
  logic                  miso_tx_q, miso_tx_d;
  logic [7:0]            miso_data_q, miso_data_d;

  logic swap_set, cmd_err, abort, arm_set;

  // cs_n is asynchronous; the third flop gives the rising-edge detect
  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      cs_s1_q <= 1'b1;
      cs_s2_q <= 1'b1;
      cs_s3_q <= 1'b1;
    end else begin
      cs_s1_q <= cs_n;
      cs_s2_q <= cs_s1_q;
      cs_s3_q <= cs_s2_q;
    end
  end

  assign active = ~cs_s2_q;
  assign cs_end = cs_s2_q & ~cs_s3_q;
  assign byte_v = mosi_rx & active;

  always_comb begin
    state_d     = state_q;
    addr_hi_d   = addr_hi_q;
    addr_d      = addr_q;
    r_d         = r_q;
    g_d         = g_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
    bright_d    = bright_q;
    miso_tx_d   = 1'b0;
    miso_data_d = miso_data_q;
    stat_pend_d = cs_end & arm_q;
    swap_set    = 1'b0;
    cmd_err     = 1'b0;
    abort       = 1'b0;
    arm_set     = 1'b0;

    if (cs_end) begin
      state_d = ST_IDLE;
      abort   = aborts_in(state_q);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (active) state_d = ST_CMD;
        end
        ST_CMD: begin
          if (byte_v) begin
            unique case (1'b1)
              mosi_data_out == OP_PIXEL:
                state_d = ST_ADDR_H;
              mosi_data_out == OP_BRIGHT:
                state_d = ST_BRIGHT;
              mosi_data_out == OP_SWAP: begin
                state_d  = ST_DISCARD;
                swap_set = 1'b1;
              end
              mosi_data_out == OP_STATUS: begin
                state_d = ST_DISCARD;
                arm_set = 1'b1;
              end
              default: begin
                state_d = ST_DISCARD;
                cmd_err = 1'b1;
              end
            endcase
          end
        end
        ST_ADDR_H: begin
          if (byte_v) begin
            addr_hi_d = mosi_data_out;
            state_d   = ST_ADDR_L;
          end
        end
        ST_ADDR_L: begin
          if (byte_v) begin
            addr_d  = PIX_ADDR_W'({addr_hi_q, mosi_data_out});
            state_d = ST_PIX_R;
          end
        end
        ST_PIX_R: begin
          if (byte_v) begin
            r_d     = mosi_data_out;
            state_d = ST_PIX_G;
          end
        end
        ST_PIX_G: begin
          if (byte_v) begin
            g_d     = mosi_data_out;
            state_d = ST_PIX_B;
          end
        end
        ST_PIX_B: begin
          if (byte_v) begin
            fb_we_d   = 1'b1;
            fb_addr_d = addr_q;
            fb_data_d = {r_q, g_q, mosi_data_out};
            addr_d    = (addr_q == ADDR_LAST) ? '0
                                              : addr_q + 1'b1;
            state_d   = ST_PIX_R;
          end
        end
        ST_BRIGHT: begin
          if (byte_v) begin
            bright_d = mosi_data_out;
            state_d  = ST_DISCARD;
          end
        end
        ST_DISCARD: ;
        default: state_d = ST_IDLE;
      endcase
    end

    if (stat_pend_q) begin
      miso_tx_d                = 1'b1;
      miso_data_d              = '0;
      miso_data_d[STAT_SWAP]   = swap_q;
      miso_data_d[STAT_CMD]    = err_cmd_q;
      miso_data_d[STAT_ABORT]  = err_abort_q;
    end

    // An ack only beats a set that arrives while already pending
    swap_d      = swap_q ? ~swap_ack : swap_set;
    err_cmd_d   = (err_cmd_q & ~stat_pend_q) | cmd_err;
    err_abort_d = (err_abort_q & ~stat_pend_q) | abort;
    arm_d       = (arm_q & ~stat_pend_q) | arm_set;
  end

  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_hi_q   <= '0;
      addr_q      <= '0;
      r_q         <= '0;
      g_q         <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      bright_q    <= 8'hFF;
      swap_q      <= 1'b0;
      err_cmd_q   <= 1'b0;
      err_abort_q <= 1'b0;
      arm_q       <= 1'b0;
      stat_pend_q <= 1'b0;
      miso_tx_q   <= 1'b0;
      miso_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_hi_q   <= addr_hi_d;
      addr_q      <= addr_d;
      r_q         <= r_d;
      g_q         <= g_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      bright_q    <= bright_d;
      swap_q      <= swap_d;
      err_cmd_q   <= err_cmd_d;
      err_abort_q <= err_abort_d;
      arm_q       <= arm_d;
      stat_pend_q <= stat_pend_d;
      miso_tx_q   <= miso_tx_d;
      miso_data_q <= miso_data_d;
    end
  end

  assign fb_we        = fb_we_q;
  assign fb_addr      = fb_addr_q;
  assign fb_data      = fb_data_q;
  assign brightness   = bright_q;
  assign swap_req     = swap_q;
  assign miso_tx      = miso_tx_q;
  assign miso_data_in = miso_data_q;

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Bench for spi_cmd_parser: directed table, corner
// sequences and random transactions against a byte-level model.
module tb_spi_cmd_parser;

  localparam int AW = 11;
  localparam int NP = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spi_cmd_parser_if #(.PIX_ADDR_W(AW)) bus ();

  always #5 clk = ~clk;

  spi_cmd_parser #(
    .PIX_ADDR_W(AW),
    .NUM_PIXELS(NP)
  ) dut (
    .clk_sb       (clk),
    .reset_n      (rst_n),
    .cs_n         (bus.cs_n),
    .mosi_rx      (bus.mosi_rx),
    .mosi_data_out(bus.mosi_data_out),
    .miso_tx      (bus.miso_tx),
    .miso_data_in (bus.miso_data_in),
    .fb_we        (bus.fb_we),
    .fb_addr      (bus.fb_addr),
    .fb_data      (bus.fb_data),
    .brightness   (bus.brightness),
    .swap_req     (bus.swap_req),
    .swap_ack     (bus.swap_ack)
  );

  typedef struct {
    int          n;
    logic [7:0]  b [9];
    int          nw;
    logic [34:0] w0;
    logic [34:0] w1;
    logic [7:0]  bright;
    bit          st_v;
    logic [7:0]  st;
  } vec_t;

  vec_t tbl [8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c_end;
  bit ack_first = 1'b0;

  logic [7:0]  tx_q [$];
  logic [34:0] exp_wq [$];
  logic [34:0] act_wq [$];
  int          miso_cyc [$];
  logic [7:0]  miso_dat [$];

  logic [7:0] m_bright;
  bit m_swap, m_errc, m_abort, m_arm, m_st_v;
  logic [7:0] m_st;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.fb_we) act_wq.push_back({bus.fb_addr, bus.fb_data});
    if (bus.miso_tx) begin
      miso_cyc.push_back(cyc);
      miso_dat.push_back(bus.miso_data_in);
    end
  end

  task automatic check(input string name, input logic [39:0] act,
                       input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int n, logic [71:0] bytes, int nw,
                              logic [34:0] w0, logic [34:0] w1,
                              logic [7:0] br, bit stv,
                              logic [7:0] st);
    vec_t v;
    v.n = n;
    for (int i = 0; i < 9; i++) v.b[i] = bytes[71-8*i -: 8];
    v.nw = nw;
    v.w0 = w0;
    v.w1 = w1;
    v.bright = br;
    v.st_v = stv;
    v.st = st;
    return v;
  endfunction

  task automatic model_reset();
    m_bright = 8'hFF;
    m_swap = 0;
    m_errc = 0;
    m_abort = 0;
    m_arm = 0;
  endtask

  // Whole-transaction view: count pixels from the byte total
  task automatic model_txn();
    int n, a, full;
    logic [7:0] op;
    n = tx_q.size();
    m_st_v = 0;
    op = (n > 0) ? tx_q[0] : 8'h00;
    if (ack_first && n > 0) m_swap = (op == 8'h03) && !m_swap;
    if (n > 0) begin
      case (op)
        8'h01: begin
          if (n < 3) m_abort = 1;
          else begin
            a = int'({tx_q[1], tx_q[2]}) % (1 << AW);
            full = (n - 3) / 3;
            for (int k = 0; k < full; k++) begin
              exp_wq.push_back({a[AW-1:0], tx_q[3+3*k],
                                tx_q[4+3*k], tx_q[5+3*k]});
              a = (a == NP - 1) ? 0 : a + 1;
            end
            if ((n - 3) % 3 != 0) m_abort = 1;
          end
        end
        8'h02: if (n >= 2) m_bright = tx_q[1];
        8'h03: if (!ack_first) m_swap = 1;
        8'h04: m_arm = 1;
        default: m_errc = 1;
      endcase
    end
    if (m_arm) begin
      m_st_v = 1;
      m_st = {5'b0, m_swap, m_errc, m_abort};
      m_arm = 0;
      m_errc = 0;
      m_abort = 0;
    end
  endtask

  task automatic compare_txn();
    check("nwr", act_wq.size(), exp_wq.size());
    for (int i = 0; i < act_wq.size() && i < exp_wq.size(); i++)
      check("wr", act_wq[i], exp_wq[i]);
    check("bright", bus.brightness, m_bright);
    check("swap", bus.swap_req, m_swap);
    check("nmiso", miso_cyc.size(), m_st_v);
    if (m_st_v && miso_cyc.size() > 0) begin
      check("miso_lat", miso_cyc[0] - c_end, 4);
      check("miso_dat", miso_dat[0], m_st);
    end
  endtask

  task automatic send_txn();
    exp_wq.delete();
    act_wq.delete();
    miso_cyc.delete();
    miso_dat.delete();
    bus.cs_n = 1'b0;
    repeat (5) @(negedge clk);
    foreach (tx_q[i]) begin
      bus.mosi_rx = 1'b1;
      bus.mosi_data_out = tx_q[i];
      if (i == 0 && ack_first) bus.swap_ack = 1'b1;
      @(negedge clk);
      bus.mosi_rx = 1'b0;
      bus.swap_ack = 1'b0;
      repeat (3) @(negedge clk);
    end
    bus.cs_n = 1'b1;
    c_end = cyc;
    repeat (10) @(negedge clk);
    model_txn();
    compare_txn();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, bus.fb_we, 0);
    check({tag, "_addr"}, bus.fb_addr, 0);
    check({tag, "_data"}, bus.fb_data, 0);
    check({tag, "_bright"}, bus.brightness, 8'hFF);
    check({tag, "_swap"}, bus.swap_req, 0);
    check({tag, "_mtx"}, bus.miso_tx, 0);
    check({tag, "_mdat"}, bus.miso_data_in, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, sel;
    bus.cs_n = 1'b1;
    bus.mosi_rx = 1'b0;
    bus.mosi_data_out = 8'h00;
    bus.swap_ack = 1'b0;
    model_reset();

    tbl[0] = mk(9, 72'h01_00_05_11_22_33_44_55_66, 2,
                {11'd5, 24'h112233}, {11'd6, 24'h445566},
                8'hFF, 0, 8'h00);
    tbl[1] = mk(9, 72'h01_07_FF_AA_BB_CC_DD_EE_FF, 2,
                {11'd2047, 24'hAABBCC}, {11'd0, 24'hDDEEFF},
                8'hFF, 0, 8'h00);
    tbl[2] = mk(3, 72'h02_40_99_00_00_00_00_00_00, 0,
                35'd0, 35'd0, 8'h40, 0, 8'h00);
    tbl[3] = mk(5, 72'h01_00_00_11_22_00_00_00_00, 0,
                35'd0, 35'd0, 8'h40, 0, 8'h00);
    tbl[4] = mk(1, 72'h04_00_00_00_00_00_00_00_00, 0,
                35'd0, 35'd0, 8'h40, 1, 8'h01);
    tbl[5] = mk(1, 72'h04_00_00_00_00_00_00_00_00, 0,
                35'd0, 35'd0, 8'h40, 1, 8'h00);
    tbl[6] = mk(1, 72'h7E_00_00_00_00_00_00_00_00, 0,
                35'd0, 35'd0, 8'h40, 0, 8'h00);
    tbl[7] = mk(1, 72'h04_00_00_00_00_00_00_00_00, 0,
                35'd0, 35'd0, 8'h40, 1, 8'h02);

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      tx_q.delete();
      for (int i = 0; i < tbl[t].n; i++) tx_q.push_back(tbl[t].b[i]);
      send_txn();
      check("t_nwr", act_wq.size(), tbl[t].nw);
      if (tbl[t].nw > 0 && act_wq.size() > 0)
        check("t_w0", act_wq[0], tbl[t].w0);
      if (tbl[t].nw > 1 && act_wq.size() > 1)
        check("t_w1", act_wq[1], tbl[t].w1);
      check("t_bright", bus.brightness, tbl[t].bright);
      if (tbl[t].st_v) begin
        check("t_nmiso", miso_dat.size(), 1);
        if (miso_dat.size() > 0) check("t_st", miso_dat[0], tbl[t].st);
      end
    end

    tx_q = '{8'h03};
    send_txn();
    repeat (5) @(negedge clk);
    check("swap_hold", bus.swap_req, 1);
    send_txn();
    tx_q = '{8'h04};
    send_txn();
    if (miso_dat.size() > 0) check("swap_st", miso_dat[0], 8'h04);
    bus.swap_ack = 1'b1;
    @(negedge clk);
    bus.swap_ack = 1'b0;
    m_swap = 0;
    check("swap_clr", bus.swap_req, 0);

    ack_first = 1'b1;
    tx_q = '{8'h03};
    send_txn();
    check("ack_set_wins", bus.swap_req, 1);
    send_txn();
    check("ack_wins", bus.swap_req, 0);
    ack_first = 1'b0;

    act_wq.delete();
    bus.cs_n = 1'b0;
    repeat (5) @(negedge clk);
    tx_q = '{8'h01, 8'h00, 8'h10, 8'h11, 8'h22};
    foreach (tx_q[i]) begin
      bus.mosi_rx = 1'b1;
      bus.mosi_data_out = tx_q[i];
      @(negedge clk);
      bus.mosi_rx = 1'b0;
      repeat (3) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("mid");
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_nowr", act_wq.size(), 0);
    tx_q = '{8'h01, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03};
    send_txn();
    if (act_wq.size() > 0)
      check("rst_wr", act_wq[0], {11'd3, 24'h010203});
    tx_q = '{8'h04};
    send_txn();

    for (int r = 0; r < 40; r++) begin
      tx_q.delete();
      ack_first = ($urandom % 6 == 0);
      n = $urandom_range(0, 11);
      sel = $urandom % 8;
      if (n > 0) begin
        case (sel)
          0, 1, 2: tx_q.push_back(8'h01);
          3: tx_q.push_back(8'h02);
          4: tx_q.push_back(8'h03);
          5: tx_q.push_back(8'h04);
          default: tx_q.push_back(8'($urandom));
        endcase
        for (int i = 1; i < n; i++) tx_q.push_back(8'($urandom));
        if (r % 4 == 0 && n >= 3) begin
          tx_q[1] = 8'h07;
          tx_q[2] = 8'hFE;
        end
      end
      send_txn();
      ack_first = 1'b0;
      if ($urandom % 3 == 0) begin
        bus.swap_ack = 1'b1;
        @(negedge clk);
        bus.swap_ack = 1'b0;
        m_swap = 0;
        check("r_ack", bus.swap_req, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_parser.md
SPI_CMD_PARSER -- requirements
Module: spi_cmd_parser

Interface
REQ-001 SHALL have parameter PIX_ADDR_W, default 11, meaning frame-buffer pixel address width (64x32 matrix).
REQ-002 SHALL have parameter NUM_PIXELS, default 2048, meaning last valid address + 1; must be <= 2**PIX_ADDR_W.
REQ-003 SHALL have clk_sb, input, 1, the system clock; the block has exactly one clock.
REQ-004 SHALL have reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have cs_n, input, 1, raw SPI chip select, asynchronous to clk_sb.
REQ-006 SHALL have mosi_rx, input, 1, one-cycle pulse marking a received byte from the SPI slave.
REQ-007 SHALL have mosi_data_out, input, 8, received byte; valid when mosi_rx is high.
REQ-008 SHALL have miso_tx, output, 1, one-cycle request to load the response byte.
REQ-009 SHALL have miso_data_in, output, 8, response byte; stable while miso_tx is high.
REQ-010 SHALL have fb_we, output, 1, one-cycle frame-buffer write strobe.
REQ-011 SHALL have fb_addr, output, PIX_ADDR_W, write address.
REQ-012 SHALL have fb_data, output, 24, pixel {R,G,B}.
REQ-013 SHALL have brightness, output, 8, global brightness register.
REQ-014 SHALL have swap_req, output, 1, buffer-swap request held until acknowledged.
REQ-015 SHALL have swap_ack, input, 1, one-cycle acknowledge from the display side.

Function
REQ-016 SHALL synchronize cs_n through 2 flops; "active" = synchronized cs_n low; "end" = synchronized 0->1 edge.
REQ-017 SHALL implement FSM states IDLE, CMD, ADDR_H, ADDR_L, PIX_R, PIX_G, PIX_B, BRIGHT, DISCARD.
REQ-018 SHALL go IDLE->CMD when active; in CMD, the first byte selects: 0x01 ->ADDR_H, 0x02 ->BRIGHT, 0x03 ->DISCARD plus swap, 0x04 ->DISCARD plus status arm, any other value ->DISCARD plus set err_cmd.
REQ-019 SHALL load the address MSB-first over ADDR_H/ADDR_L, keeping only the low PIX_ADDR_W bits, then enter PIX_R.
REQ-020 SHALL cycle PIX_R->PIX_G->PIX_B->PIX_R, capturing one byte per state; on the PIX_B byte it SHALL pulse fb_we on the next cycle with the current address and the {R,G,B} data.
REQ-021 SHALL post-increment the address after each write, wrapping from NUM_PIXELS-1 to 0.
REQ-022 SHALL, in BRIGHT, load brightness with the byte and go to DISCARD; further bytes are ignored.
REQ-023 SHALL, on 0x03, set swap_req high; swap_req clears on swap_ack; a second 0x03 while pending sets no new request.
REQ-024 SHALL return to IDLE from any state on end; an incomplete pixel or address is discarded without fb_we, and aborts in ADDR_H/ADDR_L/PIX_G/PIX_B set err_abort.
REQ-025 SHALL, when status is armed, pulse miso_tx 2 cycles after end with miso_data_in = {5'b0, swap_req, err_cmd, err_abort}, then clear err_cmd, err_abort and the arm.
REQ-026 SHALL ignore mosi_rx while not active.
REQ-027 SHALL give swap_ack priority over a swap set in the same cycle only if swap_req was already high.

Reset
REQ-028 SHALL, on reset_n low, asynchronously set: state IDLE, fb_we 0, fb_addr 0, fb_data 0, brightness 8'hFF, swap_req 0, miso_tx 0, miso_data_in 0, and clear errors, arm and sync flops (to 1).
REQ-029 SHALL, on reset during a transfer, discard the transfer and resume at the next cs_n assertion.

Structure
REQ-030 SHALL place command opcodes (0x01-0x04), the state encoding and the status bit positions in package led_ctrl_pkg.
REQ-031 SHALL be a single module with no sub-modules; the cs_n synchronizer is inline.

Verification
REQ-032 SHALL cover: bytes 01 00 05 11 22 33 44 55 66 -> fb_we twice: addr 5 data 112233, then addr 6 data 445566.
REQ-033 SHALL cover: bytes 01 07 FF AA BB CC DD EE FF -> addr 2047 then wrap to 0.
REQ-034 SHALL cover: bytes 02 40 99 -> brightness 0x40 and no fb_we; 03 -> swap_req 1 until swap_ack pulse.
REQ-035 SHALL cover: bytes 01 00 00 11 22 then cs_n high -> no fb_we; 04 transaction -> miso_tx with 0x01 two cycles after end, next read 0x00.
REQ-036 SHALL cover: opcode 0x7E then status read -> 0x02; reset_n pulsed mid-pixel -> all outputs at reset values, and next transaction writes normally.
